// File: rtl/disp_scan_mux.sv
// ---------------------------------------------------------------------------
// disp_scan_mux
//
// Time-multiplexed scanner for a bank of common-anode 7-segment digits.
// A shadow register captures valor_i on carga_i so the displayed value stays
// stable while the source changes. A prescaler advances the digit index once
// every PRESCALE cycles. The selected nibble and its anode enable are then
// presented on registered outputs. Optional leading-zero blanking keeps the
// anodes of blank digits inactive. Digit 0 is never blanked.
//
// Ports
//   clk_i          : system clock, rising edge
//   rst_n_i        : asynchronous active-low reset
//   valor_i        : value to display, nibble k = digit k (digit 0 rightmost)
//   carga_i        : load strobe, valor_i -> shadow on every edge it is 1
//   habilita_i     : scan enable, 0 freezes the scan and blanks all anodes
//   blank_ceros_i  : 1 = suppress leading zeros
//   digito_o       : nibble of the selected digit (to the hex decoder)
//   anodos_o       : one-hot digit enable, polarity set by ANODE_ACT_LOW
//   tick_o         : one-cycle pulse on each digit advance
//
// Handshake: there is no valid/ready pair. carga_i is a level-sampled strobe.
// The captured value is seen on the outputs one edge after the capture edge.
// ---------------------------------------------------------------------------
module disp_scan_mux #(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESCALE      = 50000,
  parameter bit ANODE_ACT_LOW = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [4*NUM_DIGITS-1:0] valor_i,
  input  logic                    carga_i,
  input  logic                    habilita_i,
  input  logic                    blank_ceros_i,
  output logic [3:0]              digito_o,
  output logic [NUM_DIGITS-1:0]   anodos_o,
  output logic                    tick_o
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0]         CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ANODE_ACT_LOW}};

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    tick_q, tick_d;
  logic [3:0]              digito_q, digito_d;
  logic [NUM_DIGITS-1:0]   anodos_q, anodos_d;

  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic                    zero_run;
  logic                    sel_blank;
  logic [3:0]              nib_sel;

  // Digit selection and leading-zero detection. Walking from the most
  // significant digit down, zero_run stays 1 while every nibble seen so far
  // is zero. So blank_vec[k] marks digits whose nibbles k..top are all zero.
  always_comb begin
    nib_sel   = 4'h0;
    onehot    = '0;
    blank_vec = '0;
    zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (shadow_q[4*k +: 4] == 4'h0);
      if (k != 0) begin
        blank_vec[k] = blank_ceros_i & zero_run;
      end
      if (idx_q == IW'(k)) begin
        nib_sel   = shadow_q[4*k +: 4];
        onehot[k] = 1'b1;
      end
    end
    sel_blank = |(blank_vec & onehot);
  end

  // Next-state logic. Outputs use the current idx and shadow values, so the
  // outputs lag both by one cycle.
  always_comb begin
    shadow_d = carga_i ? valor_i : shadow_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    tick_d   = 1'b0;
    if (habilita_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        tick_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + 1'b1;
      end
    end
    digito_d = nib_sel;
    if (habilita_i && !sel_blank) begin
      anodos_d = ANODE_ACT_LOW ? ~onehot : onehot;
    end else begin
      anodos_d = AN_OFF;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      tick_q   <= 1'b0;
      digito_q <= 4'h0;
      anodos_q <= AN_OFF;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      tick_q   <= tick_d;
      digito_q <= digito_d;
      anodos_q <= anodos_d;
    end
  end

  assign digito_o = digito_q;
  assign anodos_o = anodos_q;
  assign tick_o   = tick_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_disp_scan_mux
//
// Two instances share a clock and reset:
//   inst 0 : NUM_DIGITS=4, PRESCALE=4, ANODE_ACT_LOW=1
//   inst 1 : NUM_DIGITS=8, PRESCALE=3, ANODE_ACT_LOW=0
// A behavioural model predicts every output on every cycle. The model treats
// the displayed value as an integer, takes digits by shifting, and counts
// slots with plain integers. Inputs change on the falling edge. Outputs are
// compared on the falling edge as well.
// ---------------------------------------------------------------------------
module tb_disp_scan_mux;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus / DUT ----------------
  logic [31:0] in_val   [2];
  logic        in_carga [2];
  logic        in_hab   [2];
  logic        in_blank [2];

  logic [3:0] dig_a, dig_b;
  logic [3:0] an_a;
  logic [7:0] an_b;
  logic       tick_a, tick_b;

  disp_scan_mux #(.NUM_DIGITS(4), .PRESCALE(4), .ANODE_ACT_LOW(1'b1)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .valor_i(in_val[0][15:0]),
    .carga_i(in_carga[0]), .habilita_i(in_hab[0]),
    .blank_ceros_i(in_blank[0]), .digito_o(dig_a), .anodos_o(an_a),
    .tick_o(tick_a));

  disp_scan_mux #(.NUM_DIGITS(8), .PRESCALE(3), .ANODE_ACT_LOW(1'b0)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .valor_i(in_val[1]),
    .carga_i(in_carga[1]), .habilita_i(in_hab[1]),
    .blank_ceros_i(in_blank[1]), .digito_o(dig_b), .anodos_o(an_b),
    .tick_o(tick_b));

  // ---------------- reference model ----------------
  int          nd      [2] = '{4, 8};
  int          ps      [2] = '{4, 3};
  bit          act_low [2] = '{1'b1, 1'b0};

  logic [31:0] m_sh   [2];
  int          m_cnt  [2];
  int          m_idx  [2];
  logic [3:0]  e_dig  [2];
  logic [7:0]  e_an   [2];
  logic        e_tick [2];

  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] an_off(input int i);
    return act_low[i] ? 8'((1 << nd[i]) - 1) : 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sh[i]   = 32'h0;
      m_cnt[i]  = 0;
      m_idx[i]  = 0;
      e_dig[i]  = 4'h0;
      e_an[i]   = an_off(i);
      e_tick[i] = 1'b0;
    end
  endtask

  // One rising edge. Outputs come from the state before the edge.
  task automatic model_edge(input int i);
    logic [31:0] upper;
    logic [31:0] mask;
    logic [7:0]  oh;
    bit          blank;
    mask  = (nd[i] == 8) ? 32'hFFFF_FFFF : 32'((64'd1 << (4 * nd[i])) - 1);
    upper = m_sh[i] >> (4 * m_idx[i]);
    blank = in_blank[i] && (m_idx[i] != 0) && (upper == 32'h0);
    e_dig[i] = upper[3:0];
    oh = 8'(1 << m_idx[i]);
    if (in_hab[i] && !blank)
      e_an[i] = act_low[i] ? (~oh & an_off(i)) : oh;
    else
      e_an[i] = an_off(i);
    if (in_hab[i]) begin
      if (m_cnt[i] == ps[i] - 1) begin
        m_cnt[i]  = 0;
        m_idx[i]  = (m_idx[i] + 1) % nd[i];
        e_tick[i] = 1'b1;
      end else begin
        m_cnt[i]  = m_cnt[i] + 1;
        e_tick[i] = 1'b0;
      end
    end else begin
      e_tick[i] = 1'b0;
    end
    if (in_carga[i]) m_sh[i] = in_val[i] & mask;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_digito", 32'(dig_a),  32'(e_dig[0]));
    chk("a_anodos", 32'(an_a),   32'(e_an[0]));
    chk("a_tick",   32'(tick_a), 32'(e_tick[0]));
    chk("b_digito", 32'(dig_b),  32'(e_dig[1]));
    chk("b_anodos", 32'(an_b),   32'(e_an[1]));
    chk("b_tick",   32'(tick_b), 32'(e_tick[1]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int i = 0; i < 2; i++) model_edge(i);
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load(input int i, input logic [31:0] v);
    in_val[i]   = v;
    in_carga[i] = 1'b1;
    step();
    in_carga[i] = 1'b0;
  endtask

  // Advance until inst 0 reaches the wanted count (and index if idx >= 0).
  task automatic wait_slot(input string tag, input int cnt, input int idx);
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_cnt[0] == cnt && (idx < 0 || m_idx[0] == idx)) found = 1'b1;
      else step();
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  // Random value with roughly half the nibbles forced to zero.
  function automatic logic [31:0] sparse_val();
    logic [31:0] v = $urandom;
    for (int k = 0; k < 8; k++)
      if ($urandom_range(0, 1) == 0) v[4*k +: 4] = 4'h0;
    return v;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      in_val[i] = 32'h0; in_carga[i] = 1'b0; in_hab[i] = 1'b0;
      in_blank[i] = 1'b0;
    end
    model_reset();

    // Reset held across a few edges.
    steps(3);
    chk("reset_an_a", 32'(an_a), 32'h0000000F);
    chk("reset_an_b", 32'(an_b), 32'h00000000);
    rst_n = 1'b1;

    // Reset and enable: 1A3F scans F,3,A,1 with a 4-cycle slot.
    in_hab[0] = 1'b1;
    in_hab[1] = 1'b1;
    in_val[1] = 32'h89AB_CDEF;
    in_carga[1] = 1'b1;
    load(0, 32'h0000_1A3F);
    in_carga[1] = 1'b0;
    steps(40);

    // Leading-zero blanking.
    in_blank[0] = 1'b1;
    in_blank[1] = 1'b1;
    load(0, 32'h0000_0005);
    load(1, 32'h0000_0300);
    steps(20);
    load(0, 32'h0000_0000);
    steps(18);
    in_blank[0] = 1'b0;
    steps(18);

    // Enable gating: drop at cnt=2, hold, then resume.
    load(0, 32'h0000_1A3F);
    wait_slot("wait_cnt2", 2, -1);
    in_hab[0] = 1'b0;
    steps(6);
    chk("gate_off_an", 32'(an_a), 32'h0000000F);
    in_hab[0] = 1'b1;
    steps(12);

    // Load mid-scan while digit 2 is active.
    load(0, 32'h0000_1234);
    wait_slot("wait_idx2", 1, 2);
    step();
    load(0, 32'h0000_ABCD);
    steps(12);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_dig_a", 32'(dig_a), 32'h0);
    chk("async_an_a",  32'(an_a),  32'hF);
    chk("async_an_b",  32'(an_b),  32'h00);
    chk("async_tick",  32'({tick_a, tick_b}), 32'h0);
    @(negedge clk);
    steps(2);
    rst_n = 1'b1;
    in_blank[0] = 1'b1;
    steps(20);

    // Randomised traffic on both instances.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        in_val[i]   = sparse_val();
        in_carga[i] = ($urandom_range(0, 7) == 0);
        in_hab[i]   = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 31) == 0) in_blank[i] = ~in_blank[i];
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
